lsu: RTL and testbench
======================

# lsu

Load/store unit for the multi-cycle NPC core. It sits between EXU and WBU and replaces direct DPI memory access with a request/response data-bus handshake. It accepts one memory operation at a time from EXU and aligns store data and strobes. It sign- or zero-extends load data and hands the result to WBU under valid/ready. It flags misaligned accesses, bus errors and bus timeouts.

## Interface
- `TIMEOUT`, default 255: cycles in WAIT with no response before an error completion; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `exu_valid`  in  1  EXU offers an operation.
- `lsu_ready`  out  1  LSU can accept; high only in IDLE.
- `mem_ren`  in  1  load operation.
- `mem_wen`  in  1  store operation; `mem_ren` takes priority if both are high.
- `mem_width`  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes are illegal.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `lsu_valid`  out  1  result available to WBU.
- `wbu_ready`  in  1  WBU consumes the result.
- `rdata`  out  32  extended load data; 0 for stores.
- `lsu_err`  out  1  access fault; valid with `lsu_valid`.
- `req_valid`  out  1  bus request.
- `req_ready`  in  1  bus accepts the request.
- `req_wen`  out  1  write request.
- `req_addr`  out  32  `addr` with bits [1:0] forced to 0.
- `req_wdata`  out  32  store data shifted to its byte lane.
- `req_wstrb`  out  4  byte strobes; 0 on reads.
- `rsp_valid`  in  1  bus response.
- `rsp_ready`  out  1  high only in WAIT.
- `rsp_rdata`  in  32  read word.
- `rsp_err`  in  1  bus error.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `lsu_ready`=1.
  - On `exu_valid`, capture `mem_ren`, `mem_wen`, `mem_width`, `addr` and `wdata`.
  - Illegal width, or misalignment (h with addr[0]=1; w with addr[1:0]≠0): go to DONE with err=1. No bus traffic.
  - Neither `mem_ren` nor `mem_wen`: go to DONE with err=0 and rdata=0.
  - Otherwise: go to REQ.
- **REQ**
  - `req_valid`=1.
  - `req_*` are held stable from captured registers until `req_ready`.
  - On `req_ready`: go to WAIT and clear the timeout counter.
- **WAIT**
  - `rsp_ready`=1.
  - On `rsp_valid`: capture `rsp_err` into err and go to DONE.
  - Load rdata: select the byte lane by addr[1:0]. b/h are sign-extended from bit 7/15; bu/hu are zero-extended.
  - Otherwise the counter increments each cycle. When it reaches `TIMEOUT`: go to DONE with err=1 and rdata=0. A later stray response is ignored until the next WAIT.
- **DONE**
  - `lsu_valid`=1; `rdata` and `lsu_err` are held stable.
  - On `wbu_ready`: go to IDLE.
- **Store lane formatting**
  - b: `req_wdata`={4{wdata[7:0]}}, `req_wstrb`=1<<addr[1:0].
  - h: `req_wdata`={2{wdata[15:0]}}, `req_wstrb`=0011 or 1100 per addr[1].
  - w: `req_wstrb`=1111.
- **Reset**
  - State returns to IDLE immediately, including mid-transaction. All outputs go to 0 except `lsu_ready`=1.
  - Any outstanding bus transaction is abandoned; the bus side shares this reset.

## Timing
- Accept in cycle 0 (`exu_valid`&&`lsu_ready`). `req_valid` is first high in cycle 1.
- A response is never accepted in the same cycle as the request handshake. The earliest `rsp_valid` sample is the cycle after `req_ready`.
- Minimum memory-op latency: `lsu_valid` in cycle 3 (request accepted in cycle 1, response in cycle 2).
- Non-memory ops and faults: `lsu_valid` in cycle 1.
- Throughput is one operation per ≥2 cycles. `lsu_ready` returns in the cycle after the `wbu_ready` handshake; there is no bypass.
- All outputs are registered or decoded only from state and captured registers. There are no combinational paths from inputs to outputs.

## Test plan
- **Load byte, sign-extended:** lb at 0x8000_0003; rsp_rdata=0x80AA_BBCC, rsp_err=0 → req_addr=0x8000_0000, req_wstrb=0, rdata=0xFFFF_FF80, lsu_err=0, lsu_valid in cycle 3.
- **Store halfword:** sh at 0x8000_0006 with wdata=0x1234_ABCD → req_wen=1, req_wdata=0xABCD_ABCD, req_wstrb=1100. After the write ack, rdata=0 and lsu_err=0.
- **Bus back-pressure:**
  - req_ready held low 5 cycles with addr changing on the EXU side → req_addr/req_wdata stay unchanged, and lsu_ready stays 0 throughout.
  - lsu_valid held 3 cycles while wbu_ready=0 → rdata stays unchanged.
- **Misaligned and illegal:**
  - lw at 0x8000_0002 → no req_valid, and lsu_valid with lsu_err=1 in cycle 1.
  - mem_width=011 → same response.
- **Bus error and timeout:**
  - rsp_err=1 → lsu_err=1.
  - TIMEOUT=4 with no response → lsu_err=1 four cycles after entering WAIT. A late rsp_valid is then ignored, with rsp_ready=0.
- **Reset mid-WAIT:** assert rst low asynchronously → lsu_valid, req_valid and rsp_ready go to 0 immediately and lsu_ready goes to 1. A subsequent lw completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one EXU memory op at a time over a req/rsp data bus, aligned/extended result to WBU.
// Latency >= 3 cycles for bus ops, 1 for faults and non-memory ops; each side stalls on its own handshake.
module lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_valid,
   output logic        lsu_ready,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [2:0]  mem_width,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        lsu_valid,
   input  logic        wbu_ready,
   output logic [31:0] rdata,
   output logic        lsu_err,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_wen,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_wstrb,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [31:0] rsp_rdata,
   input  logic        rsp_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic           ren_q, ren_d;
   logic           wen_q, wen_d;
   logic [2:0]     width_q, width_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           illegal, misaligned;
   logic [31:0]    lane, load_ext;
   logic [31:0]    st_wdata;
   logic [3:0]     st_wstrb;
   logic           is_store, in_req;

   always_comb begin
      illegal    = !(mem_width inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned = ((mem_width[1:0] == 2'b01) && addr[0]) ||
                   ((mem_width[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   // Bring the addressed byte/halfword down to bit 0 before extending.
   always_comb begin
      lane = rsp_rdata >> {addr_q[1:0], 3'b000};
      case (width_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'b0, lane[7:0]};
         3'b101:  load_ext = {16'b0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_comb begin
      case (width_q[1:0])
         2'b00: begin
            st_wdata = {4{wdata_q[7:0]}};
            st_wstrb = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            st_wdata = {2{wdata_q[15:0]}};
            st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = wdata_q;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      ren_d   = ren_q;
      wen_d   = wen_q;
      width_d = width_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (exu_valid) begin
               ren_d   = mem_ren;
               wen_d   = mem_wen;
               width_d = mem_width;
               addr_d  = addr;
               wdata_d = wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (illegal || misaligned) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (!mem_ren && !mem_wen) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (req_ready) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (rsp_valid) begin
               err_d   = rsp_err;
               rdata_d = ren_q ? load_ext : '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TMO) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (wbu_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         width_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         width_q <= width_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // A load wins when both enables are set, so only a pure store drives write lanes.
   assign is_store  = wen_q & ~ren_q;
   assign in_req    = (state_q == S_REQ);

   assign lsu_ready = (state_q == S_IDLE);
   assign lsu_valid = (state_q == S_DONE);
   assign rsp_ready = (state_q == S_WAIT);
   assign req_valid = in_req;
   assign req_wen   = in_req & is_store;
   assign req_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign req_wdata = (in_req && is_store) ? st_wdata : '0;
   assign req_wstrb = (in_req && is_store) ? st_wstrb : '0;
   assign rdata     = rdata_q;
   assign lsu_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, randomized ops against a byte-level reference model,
// plus timeout and asynchronous-reset sequences.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, lsu_ready, mem_ren, mem_wen;
   logic [2:0]  mem_width;
   logic [31:0] addr, wdata;
   logic        lsu_valid, wbu_ready, lsu_err;
   logic [31:0] rdata;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .lsu_ready(lsu_ready),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_width(mem_width),
      .addr(addr), .wdata(wdata),
      .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
      .rdata(rdata), .lsu_err(lsu_err),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   typedef struct {
      logic        ren, wen;
      logic [2:0]  width;
      logic [31:0] addr, wdata, rsp_rdata;
      logic        rsp_err;
      logic        bus;
      logic [31:0] req_addr, req_wdata;
      logic [3:0]  req_wstrb;
      logic        req_wen;
      logic [31:0] rdata;
      logic        err;
      logic        chk_rd;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ren, wen, input logic [2:0] w,
                               input logic [31:0] a, wd, rd, input logic re,
                               input logic bus, input logic [31:0] raddr, rwd,
                               input logic [3:0] strb, input logic rwen,
                               input logic [31:0] res, input logic err, input logic chk_rd);
      vec_t v;
      v.ren = ren; v.wen = wen; v.width = w; v.addr = a; v.wdata = wd;
      v.rsp_rdata = rd; v.rsp_err = re; v.bus = bus; v.req_addr = raddr;
      v.req_wdata = rwd; v.req_wstrb = strb; v.req_wen = rwen;
      v.rdata = res; v.err = err; v.chk_rd = chk_rd;
      return v;
   endfunction

   // Reference: access size in bytes, alignment by modulo, lanes assembled byte by byte.
   function automatic vec_t model(input logic ren, wen, input logic [2:0] w,
                                  input logic [31:0] a, wd, rd, input logic re);
      vec_t v;
      int n, off;
      logic sgn;
      logic [31:0] val;
      v = mk(ren, wen, w, a, wd, rd, re, 0, a & ~32'h3, 0, 0, 0, 0, 0, 1);
      sgn = 0;
      case (w)
         3'd0: begin n = 1; sgn = 1; end
         3'd1: begin n = 2; sgn = 1; end
         3'd2: n = 4;
         3'd4: n = 1;
         3'd5: n = 2;
         default: n = 0;
      endcase
      off = int'(a % 4);
      if (n == 0 || (a % n) != 0) begin
         v.err = 1;
      end else if (ren || wen) begin
         v.bus = 1;
         v.err = re;
         if (ren) begin
            val = 0;
            for (int i = n - 1; i >= 0; i--) val = (val << 8) | ((rd >> (8 * (off + i))) & 32'hFF);
            if (sgn && val[8*n-1]) val = val - (32'h1 << (8 * n));
            if (re) v.chk_rd = 0;
            else    v.rdata = val;
         end else begin
            v.req_wen = 1;
            for (int i = 0; i < 4; i++) begin
               v.req_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
               v.req_wstrb[i] = (i >= off) && (i < off + n);
            end
         end
      end
      return v;
   endfunction

   // Starts and ends just after a falling edge with the DUT in IDLE.
   task automatic do_op(input vec_t v, input int req_dly, input int rsp_dly, input int hold, input string nm);
      chk({nm, ".ready_idle"}, 32'(lsu_ready), 32'd1);
      exu_valid = 1; mem_ren = v.ren; mem_wen = v.wen; mem_width = v.width;
      addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      exu_valid = 0; addr = $urandom; wdata = $urandom;
      mem_ren = 1'($urandom); mem_wen = 1'($urandom); mem_width = 3'($urandom);
      if (!v.bus) begin
         chk({nm, ".valid_c1"}, 32'(lsu_valid), 32'd1);
         chk({nm, ".no_req"}, 32'(req_valid), 32'd0);
         chk({nm, ".err"}, 32'(lsu_err), 32'(v.err));
         if (v.chk_rd) chk({nm, ".rdata"}, rdata, v.rdata);
      end else begin
         chk({nm, ".valid_c1"}, 32'(lsu_valid), 32'd0);
         for (int k = 0; k <= req_dly; k++) begin
            chk({nm, ".req_valid"}, 32'(req_valid), 32'd1);
            chk({nm, ".req_addr"}, req_addr, v.req_addr);
            chk({nm, ".req_wen"}, 32'(req_wen), 32'(v.req_wen));
            chk({nm, ".req_wstrb"}, 32'(req_wstrb), 32'(v.req_wstrb));
            if (v.req_wen) chk({nm, ".req_wdata"}, req_wdata, v.req_wdata);
            chk({nm, ".ready_busy"}, 32'(lsu_ready), 32'd0);
            if (k == req_dly) req_ready = 1;
            @(negedge clk);
            addr = $urandom; wdata = $urandom;
         end
         req_ready = 0;
         for (int k = 0; k <= rsp_dly; k++) begin
            chk({nm, ".rsp_ready"}, 32'(rsp_ready), 32'd1);
            chk({nm, ".req_drop"}, 32'(req_valid), 32'd0);
            chk({nm, ".valid_wait"}, 32'(lsu_valid), 32'd0);
            if (k == rsp_dly) begin
               rsp_valid = 1; rsp_rdata = v.rsp_rdata; rsp_err = v.rsp_err;
            end else begin
               rsp_rdata = $urandom; rsp_err = 1'($urandom);
            end
            @(negedge clk);
         end
         rsp_valid = 0; rsp_rdata = $urandom; rsp_err = 0;
         chk({nm, ".valid_done"}, 32'(lsu_valid), 32'd1);
         chk({nm, ".err"}, 32'(lsu_err), 32'(v.err));
         chk({nm, ".rsp_ready_done"}, 32'(rsp_ready), 32'd0);
         if (v.chk_rd) chk({nm, ".rdata"}, rdata, v.rdata);
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({nm, ".hold_valid"}, 32'(lsu_valid), 32'd1);
         chk({nm, ".hold_err"}, 32'(lsu_err), 32'(v.err));
         if (v.chk_rd) chk({nm, ".hold_rdata"}, rdata, v.rdata);
      end
      wbu_ready = 1;
      @(negedge clk);
      wbu_ready = 0;
      chk({nm, ".valid_clr"}, 32'(lsu_valid), 32'd0);
      chk({nm, ".ready_back"}, 32'(lsu_ready), 32'd1);
   endtask

   vec_t tab[14];
   logic [2:0] ld_w[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd3};

   initial begin
      rst = 0; exu_valid = 0; mem_ren = 0; mem_wen = 0; mem_width = 0;
      addr = 0; wdata = 0; wbu_ready = 0; req_ready = 0;
      rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;

      //            ren wen width   addr          wdata         rsp_rdata     re bus req_addr    req_wdata     strb rwen rdata        err chk
      tab[0]  = mk(1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h80AA_BBCC, 0, 1, 32'h8000_0000, 32'h0,        4'h0, 0, 32'hFFFF_FF80, 0, 1);
      tab[1]  = mk(0, 1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 32'h0,        0, 1, 32'h8000_0004, 32'hABCD_ABCD, 4'hC, 1, 32'h0,        0, 1);
      tab[2]  = mk(1, 0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
      tab[3]  = mk(1, 0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
      tab[4]  = mk(1, 0, 3'b100, 32'h8000_0001, 32'h0,        32'h1234_80FF, 0, 1, 32'h8000_0000, 32'h0,        4'h0, 0, 32'h0000_0080, 0, 1);
      tab[5]  = mk(1, 0, 3'b001, 32'h8000_0002, 32'h0,        32'h8001_7FFF, 0, 1, 32'h8000_0000, 32'h0,        4'h0, 0, 32'hFFFF_8001, 0, 1);
      tab[6]  = mk(1, 0, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 0, 1, 32'h8000_0000, 32'h0,        4'h0, 0, 32'h0000_F00D, 0, 1);
      tab[7]  = mk(0, 1, 3'b000, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0,        0, 1, 32'h8000_0000, 32'hEFEF_EFEF, 4'h2, 1, 32'h0,        0, 1);
      tab[8]  = mk(0, 1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 1, 32'h0,        0, 1);
      tab[9]  = mk(1, 0, 3'b010, 32'h8000_0008, 32'h0,        32'h0BAD_F00D, 1, 1, 32'h8000_0008, 32'h0,        4'h0, 0, 32'h0,        1, 0);
      tab[10] = mk(0, 0, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 1);
      tab[11] = mk(1, 0, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        1, 1);
      tab[12] = mk(1, 1, 3'b010, 32'h8000_000C, 32'h5555_5555, 32'h1122_3344, 0, 1, 32'h8000_000C, 32'h0,        4'h0, 0, 32'h1122_3344, 0, 1);
      tab[13] = mk(0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0,        1, 1, 32'h8000_0000, 32'hA5A5_A5A5, 4'h8, 1, 32'h0,        1, 1);

      #1;
      chk("rst.lsu_ready", 32'(lsu_ready), 32'd1);
      chk("rst.lsu_valid", 32'(lsu_valid), 32'd0);
      chk("rst.req_valid", 32'(req_valid), 32'd0);
      chk("rst.rsp_ready", 32'(rsp_ready), 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.lsu_err", 32'(lsu_err), 32'd0);
      chk("rst.req_addr", req_addr, 32'd0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);

      for (int i = 0; i < 14; i++)
         do_op(tab[i], (i == 1) ? 5 : 0, 0, (i == 0) ? 3 : 0, $sformatf("vec%0d", i));

      // Timeout: no response for four WAIT cycles, then a stray response in DONE and IDLE.
      exu_valid = 1; mem_ren = 1; mem_wen = 0; mem_width = 3'b010; addr = 32'h8000_0010;
      @(negedge clk);
      exu_valid = 0;
      chk("tmo.req_valid", 32'(req_valid), 32'd1);
      req_ready = 1;
      @(negedge clk);
      req_ready = 0;
      for (int k = 0; k < 4; k++) begin
         chk("tmo.rsp_ready", 32'(rsp_ready), 32'd1);
         chk("tmo.valid_wait", 32'(lsu_valid), 32'd0);
         @(negedge clk);
      end
      chk("tmo.valid", 32'(lsu_valid), 32'd1);
      chk("tmo.err", 32'(lsu_err), 32'd1);
      chk("tmo.rdata", rdata, 32'd0);
      chk("tmo.rsp_ready_off", 32'(rsp_ready), 32'd0);
      rsp_valid = 1; rsp_err = 0; rsp_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("tmo.late_valid", 32'(lsu_valid), 32'd1);
      chk("tmo.late_err", 32'(lsu_err), 32'd1);
      chk("tmo.late_rdata", rdata, 32'd0);
      wbu_ready = 1;
      @(negedge clk);
      wbu_ready = 0;
      chk("tmo.idle_ready", 32'(lsu_ready), 32'd1);
      chk("tmo.idle_rsp_ready", 32'(rsp_ready), 32'd0);
      @(negedge clk);
      rsp_valid = 0;
      chk("tmo.idle_stay", 32'(lsu_ready), 32'd1);
      chk("tmo.idle_no_valid", 32'(lsu_valid), 32'd0);

      // Asynchronous reset while waiting for a response.
      exu_valid = 1; mem_ren = 1; mem_wen = 0; mem_width = 3'b010; addr = 32'h8000_0020;
      @(negedge clk);
      exu_valid = 0;
      req_ready = 1;
      @(negedge clk);
      req_ready = 0;
      chk("arst.in_wait", 32'(rsp_ready), 32'd1);
      #2 rst = 0;
      #1;
      chk("arst.lsu_valid", 32'(lsu_valid), 32'd0);
      chk("arst.req_valid", 32'(req_valid), 32'd0);
      chk("arst.rsp_ready", 32'(rsp_ready), 32'd0);
      chk("arst.lsu_ready", 32'(lsu_ready), 32'd1);
      @(negedge clk);
      rst = 1;
      do_op(mk(1, 0, 3'b010, 32'h8000_0024, 32'h0, 32'h7777_0001, 0, 1, 32'h8000_0024, 32'h0, 4'h0, 0, 32'h7777_0001, 0, 1),
            1, 1, 0, "arst.after");

      for (int i = 0; i < 40; i++) begin
         logic r, w;
         logic [2:0] wd;
         logic [31:0] a;
         int kind;
         kind = $urandom_range(0, 9);
         a = 32'h8000_0000 | 32'($urandom_range(0, 255));
         if (kind == 0) begin
            r = 0; w = 0; wd = 3'b010; a = a & ~32'h3;
         end else if (kind <= 5) begin
            r = 1; w = 1'($urandom); wd = ld_w[$urandom_range(0, 7)];
         end else begin
            r = 0; w = 1; wd = 3'($urandom_range(0, 2));
         end
         do_op(model(r, w, wd, a, $urandom, $urandom, ($urandom_range(0, 7) == 0)),
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
               $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
